// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types and helpers for the nibble-serial adder.
//   NIB_W       width of one slice handled by the 4-bit adder
//   nibble_t    one 4-bit slice
//   nsa_state_t controller states (IDLE, ADD, DONE)
//   idx_width() width of the nibble index counter, never below 1 bit
package nibble_pkg;

  localparam int NIB_W = 4;

  typedef logic [NIB_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: request/result bundle of the nibble-serial adder.
//   start  requester -> adder  operation request, taken only while not busy
//   op_a   requester -> adder  operand A (W bits), latched on accepted start
//   op_b   requester -> adder  operand B (W bits), latched on accepted start
//   cin    requester -> adder  carry into nibble 0, latched on accepted start
//   sub    requester -> adder  subtract select (only with SERIAL_ADD_SUB_EN)
//   busy   adder -> requester  high while nibbles are being added
//   done   adder -> requester  one-cycle pulse, sum/cout valid
//   sum    adder -> requester  result (W bits), held until the next accepted start
//   cout   adder -> requester  carry out of the top nibble, held with sum
// Handshake: a request is taken on the rising edge where start=1 and busy=0
// (including the done cycle); start while busy is dropped, not queued. There is
// no backpressure on the result: done is a single-cycle strobe and the consumer
// must capture sum/cout then or read them later while they are held.
// Macro SERIAL_ADD_SUB_EN adds the sub signal.
interface nibble_serial_adder_if
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int W = NIB_W * NIBBLES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, op_a, op_b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/nibble_serial_adder_full4adder.sv
// full4Adder: plain 4-bit ripple-carry adder, {cout,s} = a + b + cin.
//   a, b  4-bit addends
//   cin   carry into bit 0
//   s     4-bit sum
//   cout  carry out of bit 3
module full4Adder
  import nibble_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t s,
  output logic    cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES*4-bit operands one nibble per clock
// through a single full4Adder instance, with a start/done handshake.
//   clk      system clock, all state on the rising edge
//   rst      asynchronous active-high reset
//   bus      nibble_serial_adder_if.slave (start/op_a/op_b/cin[/sub] in,
//            busy/done/sum/cout out)
//   state_o  current controller state, for observation
// Latency: start accepted at edge E0 writes nibble k at E(k+1); done is high in
// the cycle after E(NIBBLES). A start in the done cycle begins the next run
// with no idle gap.
// Macro SERIAL_ADD_SUB_EN: when defined, bus.sub=1 computes op_a - op_b by
// feeding inverted B nibbles with a forced carry-in of 1 (cin ignored); cout=1
// then means no borrow.
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_adder_if.slave   bus,
  output nsa_state_t             state_o
);

  localparam int                 W        = NIB_W * NIBBLES;
  localparam int                 IDX_W    = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  nibble_t add_a, add_b, add_s;
  logic    add_cin, add_cout;

  // Slice the latched operands at the current nibble.
  nibble_t b_nib;
  assign add_a = a_q[idx_q*NIB_W +: NIB_W];
  assign b_nib = b_q[idx_q*NIB_W +: NIB_W];
`ifdef SERIAL_ADD_SUB_EN
  assign add_b = sub_q ? ~b_nib : b_nib;
`else
  assign add_b = b_nib;
`endif
  assign add_cin = carry_q;

  full4Adder u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = ADD;
          idx_d   = '0;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = bus.sub;
          // Two's-complement subtract: the +1 enters as the nibble-0 carry.
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          carry_d = bus.cin;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        sum_d[idx_q*NIB_W +: NIB_W] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = add_cout;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == ADD);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES=4 main instance, NIBBLES=1 side
// instance). Expected {cout,sum} values come from a full-width arithmetic model
// and pass through a scoreboard queue.
module tb_nibble_serial_adder;
  import nibble_pkg::*;

  localparam int N  = 4;
  localparam int W  = NIB_W * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(N)) bus ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();
  nsa_state_t state, state1;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1),
    .state_o (state1)
  );

  logic [W:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Present a request for one edge, record its expected result, then scramble
  // the operand inputs to show they are not looked at again.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic s);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = s;
`endif
    bus.start = 1'b1;
    exp_q.push_back(model(a, b, c, s));
    step();
    bus.start = 1'b0;
    bus.op_a  = W'($urandom_range(0, 16'hFFFF));
    bus.op_b  = W'($urandom_range(0, 16'hFFFF));
    bus.cin   = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = 1'($urandom_range(0, 1));
`endif
  endtask

  // Called right after the accepting edge (or k0 cycles later); follows the
  // busy phase and checks the done cycle against the scoreboard.
  task automatic track_op(input int k0);
    logic [W:0] exp;
    for (int k = k0; k < N; k++) begin
      chk("busy_during_add", 32'(bus.busy), 32'd1);
      chk("done_during_add", 32'(bus.done), 32'd0);
      step();
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=%0d", exp_q.size(), 1);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("result", 32'({bus.cout, bus.sum}), 32'(exp));
    end
  endtask

  task automatic expect_idle(input string tag);
    step();
    chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.cin    = 1'b0;
    bus1.start = 1'b0;
    bus1.op_a  = '0;
    bus1.op_b  = '0;
    bus1.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub    = 1'b0;
    bus1.sub   = 1'b0;
`endif

    // Reset state.
    step();
    step();
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_sum",   32'(bus.sum),  32'd0);
    chk("rst_cout",  32'(bus.cout), 32'd0);
    chk("rst_state", 32'(state),    32'(IDLE));
    rst = 1'b0;
    step();

    // Zero operands.
    drive_start(16'h0000, 16'h0000, 1'b0, 1'b0);
    track_op(0);
    expect_idle("after_zero");

    // Carry ripples through every nibble.
    drive_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    track_op(0);
    expect_idle("after_ripple");

    // Back-to-back: second start in the done cycle.
    drive_start(16'hABCD, 16'h1234, 1'b1, 1'b0);
    track_op(0);
    drive_start(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    track_op(0);
    expect_idle("after_b2b");

    // Second start during ADD is dropped.
    drive_start(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    chk("busy_first", 32'(bus.busy), 32'd1);
    bus.op_a  = 16'h1111;
    bus.op_b  = 16'h1111;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    track_op(1);
    chk("no_extra_op", 32'(exp_q.size()), 32'd0);
    expect_idle("after_ignored");
    expect_idle("still_idle");

    // Reset in the middle of an operation (idx=2).
    drive_start(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    step();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_done",  32'(bus.done), 32'd0);
    chk("abort_sum",   32'(bus.sum),  32'd0);
    chk("abort_cout",  32'(bus.cout), 32'd0);
    chk("abort_state", 32'(state),    32'(IDLE));
    void'(exp_q.pop_back());
    step();
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      step();
      chk("no_done_after_abort", 32'(bus.done), 32'd0);
    end
    drive_start(16'h0003, 16'h0004, 1'b0, 1'b0);
    track_op(0);
    expect_idle("after_recover");

    // A few random additions.
    for (int i = 0; i < 3; i++) begin
      drive_start(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                  1'($urandom_range(0, 1)), 1'b0);
      track_op(0);
      expect_idle("after_random");
    end

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction: borrow and no-borrow; cin must be ignored.
    drive_start(16'h0005, 16'h0007, 1'b0, 1'b1);
    track_op(0);
    expect_idle("after_sub_borrow");
    drive_start(16'h0009, 16'h0002, 1'b0, 1'b1);
    track_op(0);
    expect_idle("after_sub_ok");
`endif

    // Single-nibble instance: one ADD cycle then DONE.
    bus1.op_a  = 4'hF;
    bus1.op_b  = 4'h1;
    bus1.cin   = 1'b0;
    bus1.start = 1'b1;
    exp_q.push_back((W+1)'(5'h10));
    step();
    bus1.start = 1'b0;
    chk("n1_busy", 32'(bus1.busy), 32'd1);
    chk("n1_done_low", 32'(bus1.done), 32'd0);
    step();
    chk("n1_done", 32'(bus1.done), 32'd1);
    chk("n1_result", 32'({bus1.cout, bus1.sum}), 32'(exp_q.pop_front()));
    step();
    chk("n1_done_end", 32'(bus1.done), 32'd0);
    chk("n1_state", 32'(state1), 32'(IDLE));

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
